// File: rtl/adc_code_averager.sv
// Paces ADC conversions, averages 2^LOG2_N codes per result and queues results for a valid/ready consumer.
// One result every N*(SETTLE_CYC+1)+1 cycles; a full FIFO with no pop drops the result and sets sticky overflow.
// Define ADC_AVG_ROUND_EN for round-half-up averaging; truncation otherwise.

module adc_avg_fifo #(
   parameter int W     = 7,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clr,
   input  logic                     i_push,
   input  logic [W-1:0]             i_wdat,
   input  logic                     i_pop,
   output logic [W-1:0]             o_rdat,
   output logic                     o_vld,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_drop
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_full;
   logic          w_pop;
   logic          w_push;

   assign w_full = (r_level == (AW+1)'(DEPTH));
   assign w_pop  = i_pop && (r_level != '0);
   // A pop frees the head slot on the same edge, so a push into a full FIFO is still accepted.
   assign w_push = i_push && (!w_full || w_pop);
   assign o_drop = i_push && w_full && !w_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)
            r_level <= r_level + (AW+1)'(1);
         else if (w_pop && !w_push)
            r_level <= r_level - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdat;
   end

   assign o_vld   = (r_level != '0);
   assign o_rdat  = o_vld ? r_mem[r_rd_ptr] : '0;
   assign o_level = r_level;
endmodule

module adc_code_averager #(
   parameter int CODE_W     = 7,
   parameter int LOG2_N     = 2,
   parameter int SETTLE_CYC = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          clear,
   input  logic [CODE_W-1:0]             adc_code,
   output logic                          hold,
   output logic [CODE_W-1:0]             avg_data,
   output logic                          avg_valid,
   input  logic                          avg_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);
   localparam int ACC_W = CODE_W + LOG2_N;
   localparam int CNT_W = LOG2_N + 1;
   localparam int SC_W  = $clog2(SETTLE_CYC) + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_STORE  = 2'd3;

   localparam logic [CNT_W-1:0] N_LAST  = CNT_W'((1 << LOG2_N) - 1);
   localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(SETTLE_CYC - 1);

   logic [1:0]        r_state;
   logic [SC_W-1:0]   r_scnt;
   logic [CNT_W-1:0]  r_cnt;
   logic [ACC_W-1:0]  r_acc;
   logic              r_ovf;
   logic [ACC_W-1:0]  w_acc_nxt;
   logic [CODE_W-1:0] w_result;
   logic              w_push;
   logic              w_drop;

   assign w_acc_nxt = r_acc + ACC_W'(adc_code);

`ifdef ADC_AVG_ROUND_EN
   // Sum + N/2 never exceeds ACC_W bits, so no saturation is needed.
   localparam logic [ACC_W-1:0] RND = ACC_W'((1 << LOG2_N) >> 1);
   assign w_result = CODE_W'((r_acc + RND) >> LOG2_N);
`else
   assign w_result = CODE_W'(r_acc >> LOG2_N);
`endif

   assign w_push = (r_state == S_STORE);
   assign hold   = (r_state == S_SETTLE) || (r_state == S_SAMPLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_scnt  <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
      end else if (clear) begin
         r_state <= S_IDLE;
         r_scnt  <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_state <= S_SETTLE;
                  r_scnt  <= SC_LOAD;
               end
            end
            S_SETTLE: begin
               if (r_scnt == '0)
                  r_state <= S_SAMPLE;
               else
                  r_scnt <= r_scnt - SC_W'(1);
            end
            S_SAMPLE: begin
               if (r_cnt == N_LAST) begin
                  r_acc   <= w_acc_nxt;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_state <= S_STORE;
               end else if (enable) begin
                  r_acc   <= w_acc_nxt;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_state <= S_SETTLE;
                  r_scnt  <= SC_LOAD;
               end else begin
                  // Partial window is discarded so no residue leaks into the next result.
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end
            end
            S_STORE: begin
               r_acc <= '0;
               r_cnt <= '0;
               if (enable) begin
                  r_state <= S_SETTLE;
                  r_scnt  <= SC_LOAD;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ovf <= 1'b0;
      else if (clear)
         r_ovf <= 1'b0;
      else if (w_drop)
         r_ovf <= 1'b1;
   end

   assign overflow = r_ovf;

   adc_avg_fifo #(
      .W     (CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (clear),
      .i_push  (w_push),
      .i_wdat  (w_result),
      .i_pop   (avg_ready),
      .o_rdat  (avg_data),
      .o_vld   (avg_valid),
      .o_level (fifo_level),
      .o_drop  (w_drop)
   );
endmodule
